// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with a valid/ready input handshake.
//
// Single-cycle group (op[3]=0) runs the eight-entry add/sub/or/and/not table
// where op[2:1] selects the function and op[0] is the carry-in / B-invert.
// The shift group (op[3]=1) uses an iterative unit: one bit position per
// cycle, so an n-bit shift completes n edges after it was accepted.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     op/a/b presented this cycle
//   in_ready     block can accept an op this cycle (low while shifting)
//   op[3:0]      operation select
//   a, b         operands; b[SAW-1:0] is the shift amount for shift ops
//   result       registered result, holds between ops
//   flags        registered {Z,N,C,V}
//   out_valid    one-cycle pulse per accepted op
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int SAW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             out_valid
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [1:0] SH_SHL = 2'b00;
    localparam logic [1:0] SH_SHR = 2'b01;
    localparam logic [1:0] SH_SAR = 2'b10;
    localparam logic [1:0] SH_ROL = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SAW-1:0]   cnt_q, cnt_d;
    logic [1:0]       sop_q, sop_d;
    logic [WIDTH-1:0] result_d;
    logic [3:0]       flags_d;
    logic             out_valid_d;

    function automatic logic [3:0] mkflags(input logic [WIDTH-1:0] r,
                                           input logic c, input logic v);
        return {(r == '0), r[WIDTH-1], c, v};
    endfunction

    // ------------------------------------------------------------------
    // Single-cycle unit
    // ------------------------------------------------------------------
    logic [1:0]       ctrl;
    logic             cin;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign ctrl = op[2:1];
    assign cin  = op[0];
    // cin doubles as the B-invert, so sub is A + ~B + 1 through the same adder
    assign bx   = cin ? ~b : b;
    assign sum  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ctrl)
            2'b00: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                // comparing against bx covers both add and sub overflow rules
                alu_v   = (a[WIDTH-1] == bx[WIDTH-1]) &&
                          (sum[WIDTH-1] != a[WIDTH-1]);
            end
            2'b01:   alu_res = a | bx;
            2'b10:   alu_res = a & bx;
            default: alu_res = cin ? ~b : ~a;
        endcase
    end

    // ------------------------------------------------------------------
    // One-position shift step on the accumulator
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] step_res;
    logic             step_c;

    always_comb begin
        step_res = acc_q;
        step_c   = 1'b0;
        case (sop_q)
            SH_SHL: begin
                step_res = {acc_q[WIDTH-2:0], 1'b0};
                step_c   = acc_q[WIDTH-1];
            end
            SH_SHR: begin
                step_res = {1'b0, acc_q[WIDTH-1:1]};
                step_c   = acc_q[0];
            end
            SH_SAR: begin
                step_res = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                step_c   = acc_q[0];
            end
            default: begin
                step_res = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
                step_c   = acc_q[WIDTH-1];
            end
        endcase
    end

    logic [SAW-1:0] shamt;
    assign shamt = b[SAW-1:0];

    // ------------------------------------------------------------------
    // FSM: next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sop_d       = sop_q;
        result_d    = result;
        flags_d     = flags;
        out_valid_d = 1'b0;
        in_ready    = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!op[3]) begin
                        result_d    = alu_res;
                        flags_d     = mkflags(alu_res, alu_c, alu_v);
                        out_valid_d = 1'b1;
                    end else if (op[2]) begin
                        // reserved shift encodings: complete at once with zero
                        result_d    = '0;
                        flags_d     = 4'b1000;
                        out_valid_d = 1'b1;
                    end else if (shamt == '0) begin
                        result_d    = a;
                        flags_d     = mkflags(a, 1'b0, 1'b0);
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d   = a;
                        cnt_d   = shamt;
                        sop_d   = op[1:0];
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = step_res;
                cnt_d = cnt_q - SAW'(1);
                // final step: publish straight from the shifter so the
                // accumulator's intermediate values never reach result
                if (cnt_q == SAW'(1)) begin
                    result_d    = step_res;
                    flags_d     = mkflags(step_res, step_c, 1'b0);
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sop_q     <= SH_SHL;
            result    <= '0;
            flags     <= 4'b0000;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sop_q     <= sop_d;
            result    <= result_d;
            flags     <= flags_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8). The driver pushes the expected
// result, flags and due cycle when an op is accepted; the monitor pops and
// compares on every out_valid pulse.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         out_valid;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        int           due;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .result(result), .flags(flags),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present an op at a negedge, hold it until accepted, then record the
    // expected response due lat cycles after the accept edge.
    task automatic issue(input string nm, input logic [3:0] o,
                         input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] er, input logic [3:0] ef,
                         input int lat, input bit push, output int stalls);
        bit   rdy;
        exp_t e;
        @(negedge clk);
        op = o; a = ia; b = ib; in_valid = 1'b1;
        stalls = 0;
        forever begin
            #1 rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            stalls++;
            if (stalls > 40) begin
                tests++; fails++;
                $display("FAIL %s: accept timeout after %0d cycles", nm, stalls);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.res = er; e.fl = ef; e.due = cyc + lat; e.name = nm;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_out_valid: got result %0h flags %b, required none", result, flags);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_flags"}, flags, mon_e.fl);
                chk({mon_e.name, "_cycle"}, cyc, mon_e.due);
            end
        end
    end

    initial begin
        int st;
        // in_valid asserted during reset must be ignored
        rst = 1'b1; in_valid = 1'b1; op = 4'b0000; a = 8'h11; b = 8'h22;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_result", result, 8'h00);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // arithmetic
        issue("add_7f_01", 4'b0000, 8'h7F, 8'h01, 8'h80, 4'b0101, 0, 1, st);
        issue("sub_5_5",   4'b0001, 8'h05, 8'h05, 8'h00, 4'b1010, 0, 1, st);
        chk("sub_5_5_stalls", st, 0);
        issue("sub_3_5",   4'b0001, 8'h03, 8'h05, 8'hFE, 4'b0100, 0, 1, st);
        chk("sub_3_5_stalls", st, 0);
        issue("add_ff_01", 4'b0000, 8'hFF, 8'h01, 8'h00, 4'b1010, 0, 1, st);
        issue("sub_80_01", 4'b0001, 8'h80, 8'h01, 8'h7F, 4'b0011, 0, 1, st);

        // logic sweep
        issue("or",    4'b0010, 8'hF0, 8'h3C, 8'hFC, 4'b0100, 0, 1, st);
        issue("or_nb", 4'b0011, 8'hF0, 8'h3C, 8'hF3, 4'b0100, 0, 1, st);
        issue("and",   4'b0100, 8'hF0, 8'h3C, 8'h30, 4'b0000, 0, 1, st);
        issue("and_nb",4'b0101, 8'hF0, 8'h3C, 8'hC0, 4'b0100, 0, 1, st);
        issue("not_a", 4'b0110, 8'hF0, 8'h3C, 8'h0F, 4'b0000, 0, 1, st);
        issue("not_b", 4'b0111, 8'hF0, 8'h3C, 8'hC3, 4'b0100, 0, 1, st);
        chk("logic_stalls", st, 0);

        // shifts
        issue("shl_81_3", 4'b1000, 8'h81, 8'h03, 8'h08, 4'b0000, 3, 1, st);
        chk("shl_busy_in_ready", in_ready, 1'b0);
        issue("sar_81_3", 4'b1010, 8'h81, 8'h03, 8'hF0, 4'b0100, 3, 1, st);
        chk("sar_wait_stalls", st, 3);
        issue("rol_81_3", 4'b1011, 8'h81, 8'h03, 8'h0C, 4'b0000, 3, 1, st);
        issue("shr_81_1", 4'b1001, 8'h81, 8'h01, 8'h40, 4'b0010, 1, 1, st);
        issue("shl_81_0", 4'b1000, 8'h81, 8'h00, 8'h81, 4'b0100, 0, 1, st);
        chk("shl_81_0_stalls", st, 1);

        // reset mid-shift: no response expected
        issue("shl_abort", 4'b1000, 8'h01, 8'h07, 8'h00, 4'b0000, 7, 0, st);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_result", result, 8'h00);
        chk("abort_flags", flags, 4'b0000);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        issue("add_2_2", 4'b0000, 8'h02, 8'h02, 8'h04, 4'b0000, 0, 1, st);

        // reserved shift encoding
        issue("reserved", 4'b1100, 8'hAA, 8'h03, 8'h00, 4'b1000, 0, 1, st);

        // stall rule: add held during a 5-step shift
        issue("shl_01_5", 4'b1000, 8'h01, 8'h05, 8'h20, 4'b0000, 5, 1, st);
        issue("add_held", 4'b0000, 8'h10, 8'h20, 8'h30, 4'b0000, 0, 1, st);
        chk("add_held_stalls", st, 5);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
